// File: rtl/seq_unpacker.sv
// seq_unpacker: unpacks a multi-lane sequence packet into one sequence per beat.
// Lanes whose mask bit is clear are skipped; the final beat of an end-of-job
// packet carries o_last/o_delim and the packet's overlap information.
// Optional feature macro: SEQ_UNPACKER_TRIM_EN -- trims the overlap from the
// match length on the o_last beat instead of forwarding it on o_overlap.

`ifndef SEQ_PACKET_SIZE
`define SEQ_PACKET_SIZE 4
`endif
`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 8
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 8
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif

module seq_unpacker #(
    parameter int PACKET_SIZE = `SEQ_PACKET_SIZE,
    parameter int LL_BITS     = `SEQ_LL_BITS,
    parameter int ML_BITS     = `SEQ_ML_BITS,
    parameter int OFFSET_BITS = `SEQ_OFFSET_BITS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    output logic                              i_ready,
    input  logic [PACKET_SIZE-1:0]             i_mask,
    input  logic [PACKET_SIZE*LL_BITS-1:0]     i_ll,
    input  logic [PACKET_SIZE*ML_BITS-1:0]     i_ml,
    input  logic [PACKET_SIZE*OFFSET_BITS-1:0] i_offset,
    input  logic [ML_BITS-1:0]                 i_overlap,
    input  logic                              i_eoj,
    input  logic                              i_delim,
    output logic                              o_valid,
    input  logic                              o_ready,
    output logic [LL_BITS-1:0]                 o_ll,
    output logic [ML_BITS-1:0]                 o_ml,
    output logic [OFFSET_BITS-1:0]             o_offset,
    output logic [ML_BITS-1:0]                 o_overlap,
    output logic                              o_last,
    output logic                              o_delim
);

    localparam int LANE_W = $clog2(PACKET_SIZE);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t                           state, state_d;
    logic [PACKET_SIZE-1:0]             rem_mask;
    logic [PACKET_SIZE*LL_BITS-1:0]     ll_q;
    logic [PACKET_SIZE*ML_BITS-1:0]     ml_q;
    logic [PACKET_SIZE*OFFSET_BITS-1:0] off_q;
    logic [ML_BITS-1:0]                 overlap_q;
    logic                              eoj_q;
    logic                              delim_q;

    logic [LANE_W-1:0]                 lane;
    logic [PACKET_SIZE-1:0]             lane_bit;
    logic                              marker;
    logic                              final_beat;
    logic                              accept;
    logic                              fire;
    logic                              has_work;
    logic [ML_BITS-1:0]                 ml_lane;

    // Lowest-index pending lane; a held packet with an empty mask is the end marker.
    always_comb begin
        lane     = '0;
        lane_bit = '0;
        for (int unsigned i = 0; i < PACKET_SIZE; i++) begin
            if (rem_mask[i] && (lane_bit == '0)) begin
                lane        = i[LANE_W-1:0];
                lane_bit[i] = 1'b1;
            end
        end
        marker     = (rem_mask == '0);
        final_beat = marker || ($countones(rem_mask) == 1);
        has_work   = (i_mask != '0) || i_eoj;
        o_valid    = !rst && (state == S_EMIT);
        i_ready    = !rst && ((state == S_IDLE) || (final_beat && o_ready));
        accept     = i_valid && i_ready;
        fire       = o_valid && o_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next state: a new packet may replace the current one on its final beat.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (accept && has_work) state_d = S_EMIT;
            S_EMIT: begin
                if (accept)                  state_d = has_work ? S_EMIT : S_IDLE;
                else if (fire && final_beat) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Held packet and remaining-lane mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_mask  <= '0;
            ll_q      <= '0;
            ml_q      <= '0;
            off_q     <= '0;
            overlap_q <= '0;
            eoj_q     <= 1'b0;
            delim_q   <= 1'b0;
        end else if (accept) begin
            rem_mask  <= i_mask;
            ll_q      <= i_ll;
            ml_q      <= i_ml;
            off_q     <= i_offset;
            overlap_q <= i_overlap;
            eoj_q     <= i_eoj;
            delim_q   <= i_delim;
        end else if (fire) begin
            rem_mask  <= rem_mask & ~lane_bit;
        end
    end

    // Beat outputs: zero whenever no beat is presented, zero data on the marker.
    always_comb begin
        o_ll      = '0;
        o_ml      = '0;
        o_offset  = '0;
        o_overlap = '0;
        o_last    = 1'b0;
        o_delim   = 1'b0;
        ml_lane   = '0;
        if (o_valid) begin
            o_last  = eoj_q && final_beat;
            o_delim = o_last && delim_q;
            if (!marker) begin
                o_ll     = ll_q[lane*LL_BITS +: LL_BITS];
                o_offset = off_q[lane*OFFSET_BITS +: OFFSET_BITS];
                ml_lane  = ml_q[lane*ML_BITS +: ML_BITS];
            end
`ifdef SEQ_UNPACKER_TRIM_EN
            if (o_last) o_ml = (ml_lane > overlap_q) ? (ml_lane - overlap_q) : '0;
            else        o_ml = ml_lane;
`else
            o_ml = ml_lane;
            if (o_last) o_overlap = overlap_q;
`endif
        end
    end

endmodule
